// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: step encoding, opcodes,
// ALU op codes, flag bit positions and the datapath control vector.
package cpu_pkg;

  localparam int NUM_STEPS = 6;
  localparam int REG_COUNT = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S4   = 3'd4,
    ST_S5   = 3'd5,
    ST_S6   = 3'd6
  } step_e;

  localparam logic [2:0] OP_LD   = 3'b000;
  localparam logic [2:0] OP_ST   = 3'b001;
  localparam logic [2:0] OP_DATA = 3'b010;
  localparam logic [2:0] OP_JMPR = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_JC   = 3'b101;
  localparam logic [2:0] OP_CLF  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_CMP = 3'b111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_E = 1;
  localparam int FLAG_A = 2;
  localparam int FLAG_C = 3;

  typedef struct packed {
    logic                 bus1;
    logic                 iar_en;
    logic                 iar_set;
    logic                 mar_set;
    logic                 ram_en;
    logic                 ram_set;
    logic                 ir_set;
    logic                 acc_en;
    logic                 acc_set;
    logic                 tmp_set;
    logic                 flags_set;
    logic [REG_COUNT-1:0] reg_en;
    logic [REG_COUNT-1:0] reg_set;
    logic [2:0]           alu_op;
  } ctrl_t;

  function automatic logic [REG_COUNT-1:0] reg_sel(input logic [1:0] r);
    logic [REG_COUNT-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Front-panel controls, IR/flags inputs and datapath control lines between
// the sequencer (master) and the datapath/panel (slave).
interface control_sequencer_if;
  import cpu_pkg::*;

  logic                 run;
  logic                 step_req;
  logic                 step_ack;
  logic [7:0]           ir;
  logic [3:0]           flags;
  logic [NUM_STEPS-1:0] step;
  logic                 instr_done;
  ctrl_t                ctrl;

  modport master (
    input  run, step_req, ir, flags,
    output step_ack, step, instr_done, ctrl
  );

  modport slave (
    output run, step_req, ir, flags,
    input  step_ack, step, instr_done, ctrl
  );
endinterface

// File: rtl/step_decode.sv
// Combinational decode of (step, IR, flags) into the datapath control vector.
// Any line not explicitly raised for a step stays 0; alu_op defaults to ADD.
module step_decode import cpu_pkg::*; (
  input  step_e      state,
  input  logic [7:0] ir,
  input  logic [3:0] flags,
  output ctrl_t      ctrl
);
  logic [1:0] ra, rb;
  logic [2:0] op;
  logic       is_alu;

  assign ra     = ir[3:2];
  assign rb     = ir[1:0];
  assign op     = ir[6:4];
  assign is_alu = ir[7];

  always_comb begin
    ctrl = '0;
    case (state)
      ST_S1: begin
        ctrl.bus1 = 1'b1; ctrl.iar_en = 1'b1; ctrl.mar_set = 1'b1; ctrl.acc_set = 1'b1;
      end
      ST_S2: begin ctrl.ram_en = 1'b1; ctrl.ir_set  = 1'b1; end
      ST_S3: begin ctrl.acc_en = 1'b1; ctrl.iar_set = 1'b1; end
      ST_S4: begin
        if (is_alu) begin
          ctrl.reg_en = reg_sel(rb); ctrl.tmp_set = 1'b1;
        end else begin
          case (op)
            OP_LD, OP_ST: begin ctrl.reg_en = reg_sel(ra); ctrl.mar_set = 1'b1; end
            OP_DATA, OP_JC: begin
              ctrl.bus1 = 1'b1; ctrl.iar_en = 1'b1; ctrl.mar_set = 1'b1; ctrl.acc_set = 1'b1;
            end
            OP_JMPR: begin ctrl.reg_en = reg_sel(rb); ctrl.iar_set = 1'b1; end
            OP_JMP:  begin ctrl.iar_en = 1'b1; ctrl.mar_set = 1'b1; end
            // Clear flags: ALU adds with bus1 forced and no carry-in while flags latch
            OP_CLF:  begin ctrl.bus1 = 1'b1; ctrl.flags_set = 1'b1; end
            default: ;
          endcase
        end
      end
      ST_S5: begin
        if (is_alu) begin
          ctrl.reg_en = reg_sel(ra); ctrl.alu_op = op;
          ctrl.acc_set = 1'b1; ctrl.flags_set = 1'b1;
        end else begin
          case (op)
            OP_LD, OP_DATA: begin ctrl.ram_en = 1'b1; ctrl.reg_set = reg_sel(rb); end
            OP_ST:  begin ctrl.reg_en = reg_sel(rb); ctrl.ram_set = 1'b1; end
            OP_JMP: begin ctrl.ram_en = 1'b1; ctrl.iar_set = 1'b1; end
            OP_JC:  begin ctrl.acc_en = 1'b1; ctrl.iar_set = 1'b1; end
            default: ;
          endcase
        end
      end
      ST_S6: begin
        if (is_alu) begin
          if (op != ALU_CMP) begin ctrl.acc_en = 1'b1; ctrl.reg_set = reg_sel(rb); end
        end else begin
          case (op)
            OP_DATA: begin ctrl.acc_en = 1'b1; ctrl.iar_set = 1'b1; end
            OP_JC: if ((ir[3:0] & flags) != 4'b0000) begin
              ctrl.ram_en = 1'b1; ctrl.iar_set = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// Six-step instruction sequencer: step FSM with free-run / single-step control
// and edge-detected step requests; control lines decoded by step_decode.
module control_sequencer import cpu_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  control_sequencer_if.master bus
);
  step_e                state_q, state_d;
  logic                 step_req_q, step_req_d;
  logic                 req_rise, ack;
  ctrl_t                dec_ctrl;
  logic [NUM_STEPS-1:0] step_oh;

  step_decode u_dec (
    .state (state_q),
    .ir    (bus.ir),
    .flags (bus.flags),
    .ctrl  (dec_ctrl)
  );

  assign req_rise = bus.step_req & ~step_req_q;

  always_comb begin
    state_d    = state_q;
    step_req_d = bus.step_req;
    ack        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          state_d = ST_S1;
        end else if (req_rise) begin
          state_d = ST_S1;
          ack     = 1'b1;
        end
      end
      ST_S1:   state_d = ST_S2;
      ST_S2:   state_d = ST_S3;
      ST_S3:   state_d = ST_S4;
      ST_S4:   state_d = ST_S5;
      ST_S5:   state_d = ST_S6;
      ST_S6:   state_d = bus.run ? ST_S1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_req_q <= step_req_d;
    end
  end

  always_comb begin
    step_oh = '0;
    case (state_q)
      ST_S1:   step_oh = 6'b000001;
      ST_S2:   step_oh = 6'b000010;
      ST_S3:   step_oh = 6'b000100;
      ST_S4:   step_oh = 6'b001000;
      ST_S5:   step_oh = 6'b010000;
      ST_S6:   step_oh = 6'b100000;
      default: step_oh = '0;
    endcase
  end

  // Gate with rst_n so an aborted instruction issues no partial set in the reset cycle
  assign bus.ctrl       = rst_n ? dec_ctrl : '0;
  assign bus.step       = rst_n ? step_oh : '0;
  assign bus.instr_done = rst_n & (state_q == ST_S6);
  assign bus.step_ack   = rst_n & ack;
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: bus-transfer reference model plus
// directed and randomized scenarios.
module tb_control_sequencer;
  import cpu_pkg::*;

  localparam int D_MAR = 1, D_IAR = 2, D_IR = 4, D_ACC = 8, D_TMP = 16, D_FLG = 32, D_RAM = 64;

  logic clk;
  logic rst_n;
  int   checks, fails;
  int   k;          // model step: 0 = idle, 1..6 = S1..S6
  logic prev_req;   // model of last sampled step_req

  control_sequencer_if sif();

  control_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(sif));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  // Each step is a bus transfer: one source, a set of destinations, optional bus1/ALU op
  function automatic logic [29:0] model(input int kk, input logic [7:0] i, input logic [3:0] f,
                                        input logic rn, input logic ack);
    int src, rdst, ra, rb, dst;
    logic b1;
    logic [2:0] op, aop;
    ctrl_t c;
    logic [5:0] st;
    src = 0; rdst = -1; dst = 0; b1 = 1'b0; aop = 3'b000;
    ra = int'(i[3:2]); rb = int'(i[1:0]); op = i[6:4];
    if (kk == 1) begin src = 1; b1 = 1'b1; dst = D_MAR | D_ACC; end
    if (kk == 2) begin src = 2; dst = D_IR; end
    if (kk == 3) begin src = 3; dst = D_IAR; end
    if (kk >= 4) begin
      if (i[7]) begin
        if (kk == 4) begin src = 4 + rb; dst = D_TMP; end
        if (kk == 5) begin src = 4 + ra; aop = op; dst = D_ACC | D_FLG; end
        if (kk == 6 && op != 3'b111) begin src = 3; rdst = rb; end
      end else begin
        case (op)
          3'd0: if (kk == 4) begin src = 4 + ra; dst = D_MAR; end
                else if (kk == 5) begin src = 2; rdst = rb; end
          3'd1: if (kk == 4) begin src = 4 + ra; dst = D_MAR; end
                else if (kk == 5) begin src = 4 + rb; dst = D_RAM; end
          3'd2: if (kk == 4) begin src = 1; b1 = 1'b1; dst = D_MAR | D_ACC; end
                else if (kk == 5) begin src = 2; rdst = rb; end
                else begin src = 3; dst = D_IAR; end
          3'd3: if (kk == 4) begin src = 4 + rb; dst = D_IAR; end
          3'd4: if (kk == 4) begin src = 1; dst = D_MAR; end
                else if (kk == 5) begin src = 2; dst = D_IAR; end
          3'd5: if (kk == 4) begin src = 1; b1 = 1'b1; dst = D_MAR | D_ACC; end
                else if (kk == 5) begin src = 3; dst = D_IAR; end
                else if ((i[3:0] & f) != 4'b0) begin src = 2; dst = D_IAR; end
          3'd6: if (kk == 4) begin b1 = 1'b1; dst = D_FLG; end
          default: ;
        endcase
      end
    end
    c = '0;
    c.bus1      = b1;
    c.iar_en    = (src == 1);
    c.ram_en    = (src == 2);
    c.acc_en    = (src == 3);
    if (src >= 4) c.reg_en[src-4] = 1'b1;
    c.mar_set   = (dst & D_MAR) != 0;
    c.iar_set   = (dst & D_IAR) != 0;
    c.ir_set    = (dst & D_IR)  != 0;
    c.acc_set   = (dst & D_ACC) != 0;
    c.tmp_set   = (dst & D_TMP) != 0;
    c.flags_set = (dst & D_FLG) != 0;
    c.ram_set   = (dst & D_RAM) != 0;
    if (rdst >= 0) c.reg_set[rdst] = 1'b1;
    c.alu_op    = aop;
    st = 6'b0;
    if (kk > 0) st[kk-1] = 1'b1;
    if (!rn) return 30'b0;
    return {c, st, (kk == 6), ack};
  endfunction

  function automatic logic exp_ack();
    return rst_n && k == 0 && !sif.run && sif.step_req && !prev_req;
  endfunction

  function automatic logic [29:0] model_now();
    return model(k, sif.ir, sif.flags, rst_n, exp_ack());
  endfunction

  function automatic logic [29:0] obs();
    return {sif.ctrl, sif.step, sif.instr_done, sif.step_ack};
  endfunction

  task automatic drive(input logic r, input logic rn, input logic rq,
                       input logic [7:0] i, input logic [3:0] f);
    sif.run = r; rst_n = rn; sif.step_req = rq; sif.ir = i; sif.flags = f;
    #1;
  endtask

  // Advance the model across the next rising edge and wait for the sampling point
  task automatic adv();
    int nk;
    logic rise;
    rise = sif.step_req && !prev_req;
    if (!rst_n)       nk = 0;
    else if (k == 0)  nk = (sif.run || rise) ? 1 : 0;
    else if (k == 6)  nk = sif.run ? 1 : 0;
    else              nk = k + 1;
    @(negedge clk);
    prev_req = rst_n ? sif.step_req : 1'b0;
    k = nk;
  endtask

  task automatic to_idle();
    drive(1'b0, 1'b1, 1'b0, sif.ir, sif.flags);
    for (int n = 0; n < 8 && k != 0; n++) adv();
    adv();
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    adv();
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (obs() !== model_now()) begin
        fails++; $display("FAIL reset_state got %h want %h", obs(), model_now());
      end
      adv();
    end
    drive(1'b1, 1'b1, 1'b0, 8'h01, 4'h0);
    for (int n = 0; n < 8 && k != 4; n++) begin
      checks++;
      if (obs() !== model_now()) begin
        fails++; $display("FAIL ld_before_abort k=%0d got %h want %h", k, obs(), model_now());
      end
      adv();
    end
    checks++;
    if (sif.ctrl.reg_en !== 4'b0001 || sif.ctrl.mar_set !== 1'b1 || sif.step !== 6'b001000) begin
      fails++; $display("FAIL ld_s4 got reg_en=%b mar_set=%b step=%b want 0001 1 001000",
                        sif.ctrl.reg_en, sif.ctrl.mar_set, sif.step);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h01, 4'h0);
    checks++;
    if (obs() !== 30'b0) begin
      fails++; $display("FAIL reset_cycle_gated got %h want 0", obs());
    end
    adv();
    drive(1'b1, 1'b1, 1'b0, 8'h01, 4'h0);
    checks++;
    if (obs() !== 30'b0) begin
      fails++; $display("FAIL idle_after_reset got %h want 0", obs());
    end
    adv();
    checks++;
    if (sif.step !== 6'b000001) begin
      fails++; $display("FAIL s1_after_release got step=%b want 000001", sif.step);
    end
  endtask

  task automatic test_alu_add();
    to_idle();
    drive(1'b1, 1'b1, 1'b0, 8'h81, 4'($urandom));
    adv();
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (obs() !== model_now()) begin
        fails++; $display("FAIL add_model k=%0d got %h want %h", k, obs(), model_now());
      end
      if (k == 4) begin
        checks++;
        if (sif.ctrl.reg_en !== 4'b0010 || sif.ctrl.tmp_set !== 1'b1) begin
          fails++; $display("FAIL add_s4 got reg_en=%b tmp_set=%b want 0010 1",
                            sif.ctrl.reg_en, sif.ctrl.tmp_set);
        end
      end
      if (k == 5) begin
        checks++;
        if (sif.ctrl.reg_en !== 4'b0001 || sif.ctrl.alu_op !== 3'b000 || sif.ctrl.acc_set !== 1'b1) begin
          fails++; $display("FAIL add_s5 got reg_en=%b alu_op=%b acc_set=%b want 0001 000 1",
                            sif.ctrl.reg_en, sif.ctrl.alu_op, sif.ctrl.acc_set);
        end
      end
      if (k == 6) begin
        checks++;
        if (sif.ctrl.reg_set !== 4'b0010 || sif.ctrl.acc_en !== 1'b1) begin
          fails++; $display("FAIL add_s6 got reg_set=%b acc_en=%b want 0010 1",
                            sif.ctrl.reg_set, sif.ctrl.acc_en);
        end
      end
      adv();
    end
  endtask

  task automatic test_cmp();
    to_idle();
    drive(1'b1, 1'b1, 1'b0, 8'hF1, 4'($urandom));
    adv();
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (obs() !== model_now()) begin
        fails++; $display("FAIL cmp_model k=%0d got %h want %h", k, obs(), model_now());
      end
      if (k == 5) begin
        checks++;
        if (sif.ctrl.flags_set !== 1'b1 || sif.ctrl.alu_op !== 3'b111) begin
          fails++; $display("FAIL cmp_s5 got flags_set=%b alu_op=%b want 1 111",
                            sif.ctrl.flags_set, sif.ctrl.alu_op);
        end
      end
      if (k == 6) begin
        checks++;
        if (sif.ctrl.reg_set !== 4'b0000 || sif.ctrl.acc_en !== 1'b0) begin
          fails++; $display("FAIL cmp_s6 got reg_set=%b acc_en=%b want 0000 0",
                            sif.ctrl.reg_set, sif.ctrl.acc_en);
        end
      end
      adv();
    end
  endtask

  task automatic test_jc();
    logic [3:0] fl [2];
    fl[0] = 4'b0010; fl[1] = 4'b0001;
    for (int t = 0; t < 2; t++) begin
      to_idle();
      drive(1'b1, 1'b1, 1'b0, 8'h52, fl[t]);
      adv();
      for (int n = 0; n < 6; n++) begin
        checks++;
        if (obs() !== model_now()) begin
          fails++; $display("FAIL jc_model flags=%b k=%0d got %h want %h", fl[t], k, obs(), model_now());
        end
        if (k == 6) begin
          checks++;
          if (t == 0 && (sif.ctrl.iar_set !== 1'b1 || sif.ctrl.ram_en !== 1'b1)) begin
            fails++; $display("FAIL jc_taken got iar_set=%b ram_en=%b want 1 1",
                              sif.ctrl.iar_set, sif.ctrl.ram_en);
          end
          if (t == 1 && sif.ctrl !== '0) begin
            fails++; $display("FAIL jc_not_taken got ctrl=%h want 0", sif.ctrl);
          end
        end
        adv();
      end
    end
  endtask

  task automatic test_single_step();
    int acks, s1s;
    acks = 0; s1s = 0;
    to_idle();
    drive(1'b0, 1'b1, 1'b1, 8'($urandom), 4'($urandom));
    for (int n = 0; n < 20; n++) begin
      checks++;
      if (obs() !== model_now()) begin
        fails++; $display("FAIL step_model cyc=%0d k=%0d got %h want %h", n, k, obs(), model_now());
      end
      if (sif.step_ack === 1'b1) acks++;
      if (sif.step[0] === 1'b1) s1s++;
      adv();
    end
    checks++;
    if (acks != 1 || s1s != 1 || sif.step !== 6'b0) begin
      fails++; $display("FAIL single_step got acks=%0d s1=%0d step=%b want 1 1 000000",
                        acks, s1s, sif.step);
    end
  endtask

  task automatic test_run_drop();
    int dones;
    dones = 0;
    to_idle();
    drive(1'b1, 1'b1, 1'b0, 8'($urandom), 4'($urandom));
    for (int n = 0; n < 12; n++) begin
      if (k == 2 && sif.run) drive(1'b0, 1'b1, 1'b0, sif.ir, sif.flags);
      checks++;
      if (obs() !== model_now()) begin
        fails++; $display("FAIL run_drop_model k=%0d got %h want %h", k, obs(), model_now());
      end
      if (sif.instr_done === 1'b1) dones++;
      adv();
    end
    checks++;
    if (dones != 1 || sif.step !== 6'b0) begin
      fails++; $display("FAIL run_drop got done_pulses=%0d step=%b want 1 000000", dones, sif.step);
    end
  endtask

  task automatic test_sweep();
    int drv;
    to_idle();
    drive(1'b1, 1'b1, 1'b0, 8'h00, 4'h0);
    adv();
    for (int i = 0; i < 256; i++) begin
      for (int f = 0; f < 16; f++) begin
        drive(1'b1, 1'b1, 1'b0, 8'(i), 4'(f));
        for (int s = 0; s < 6; s++) begin
          drv = int'(sif.ctrl.iar_en) + int'(sif.ctrl.ram_en) + int'(sif.ctrl.acc_en)
              + $countones(sif.ctrl.reg_en);
          checks++;
          if (drv > 1) begin
            fails++; $display("FAIL bus_one_hot ir=%h flags=%b k=%0d got %0d drivers want <=1", i, f, k, drv);
          end
          checks++;
          if (obs() !== model_now()) begin
            fails++; $display("FAIL sweep_model ir=%h flags=%b k=%0d got %h want %h",
                              i, f, k, obs(), model_now());
          end
          adv();
        end
      end
    end
  endtask

  task automatic test_random();
    logic r, rq, rn;
    for (int n = 0; n < 800; n++) begin
      r  = ($urandom_range(0, 3) == 0);
      rq = 1'($urandom_range(0, 1));
      rn = ($urandom_range(0, 40) != 0);
      drive(r, rn, rq, (k <= 1) ? 8'($urandom) : sif.ir, 4'($urandom));
      checks++;
      if (obs() !== model_now()) begin
        fails++; $display("FAIL random cyc=%0d k=%0d ir=%h got %h want %h", n, k, sif.ir, obs(), model_now());
      end
      adv();
    end
  endtask

  initial begin
    checks = 0; fails = 0; k = 0; prev_req = 1'b0;
    test_reset();
    test_alu_add();
    test_cmp();
    test_jc();
    test_single_step();
    test_run_drop();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
